// File: rtl/key_enc_pkg.sv
// Shared types and helpers for the keypad encoder.
//   key_state_e : press-tracking FSM states
//   dbg_t       : debug view of the encoder (FSM state, FIFO full flag)
//   MAX_KEYS    : widest keypad the priority encoder handles
//   CNT_W       : debounce counter width for the default DEBOUNCE_CYCLES
//   prio_enc()  : index of the lowest set bit (0 when none set)
package key_enc_pkg;

  localparam int MAX_KEYS            = 64;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int CNT_W               = $clog2(DEF_DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_e;

  typedef struct packed {
    key_state_e state;
    logic       fifo_full;
  } dbg_t;

  // Scans from the top down so the lowest set index is the last one written.
  function automatic int unsigned prio_enc(input logic [MAX_KEYS-1:0] v);
    prio_enc = 0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = i;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO for key codes.
//   clk, resetn      : clock, synchronous active-low reset
//   push, push_data  : enqueue request and data
//   pop              : dequeue head (ignored when empty)
//   rd_data          : head entry, 0 when empty
//   full, empty      : occupancy flags
//   count            : entries held
//   overflow         : sticky, set when a push is dropped on a full queue
// Handshake: push is accepted when not full, or when full and pop is
// asserted in the same cycle; pop takes effect only when not empty.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    // Pointers are power-of-two wide so increments wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    if (push && !do_push)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/key_encoder_buf.sv
// Keypad encoder: synchronises and debounces raw keys, priority-encodes the
// lowest pressed key and queues one code per press/release cycle.
//   clk, resetn : clock, synchronous active-low reset
//   enablen     : active-low enable; high forces the FSM idle
//   key         : raw asynchronous key levels, 1 = pressed
//   pop         : consume the head code
//   code, valid : show-ahead FIFO head (0 when empty) and non-empty flag
//   count       : queued entries
//   pressed     : debounced key currently held
//   overflow    : sticky, a code was dropped on a full queue
//   dbg         : FSM state and FIFO full flag
module key_encoder_buf
  import key_enc_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enablen,
  input  logic [NUM_KEYS-1:0]           key,
  input  logic                          pop,
  output logic [CODE_W-1:0]             code,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          pressed,
  output logic                          overflow,
  output dbg_t                          dbg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  key_state_e          state_q, state_d;
  logic [DB_W-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0]   lat_q, lat_d;

  logic              any;
  logic [CODE_W-1:0] cand;
  logic              last_sample;
  logic              push;
  logic [CODE_W-1:0] push_code;
  logic              fifo_empty;
  logic              fifo_full;

  // Two-flop synchroniser; the second stage is the sample the FSM sees.
  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
  end

  assign any  = |sync2_q;
  assign cand = CODE_W'(prio_enc(MAX_KEYS'(sync2_q)));
  // True when the sample being taken completes a debounce window.
  assign last_sample = (cnt_q + DB_W'(1)) == DB_W'(DEBOUNCE_CYCLES);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // Next state. Entering DEBOUNCE or RELEASE already counts one sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    if (enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            lat_d = cand;
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = HELD;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = DB_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!any || cand != lat_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (last_sample) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
        HELD: begin
          if (!any) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = IDLE;
            end else begin
              state_d = RELEASE;
              cnt_d   = DB_W'(1);
            end
          end
        end
        RELEASE: begin
          if (any) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (last_sample) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs. The push is issued on the edge that accepts the press.
  always_comb begin
    pressed   = (state_q == HELD);
    push      = 1'b0;
    push_code = lat_q;
    if (!enablen) begin
      if (state_q == IDLE && any && DEBOUNCE_CYCLES == 1) begin
        push      = 1'b1;
        push_code = cand;
      end else if (state_q == DEBOUNCE && any && cand == lat_q && last_sample) begin
        push = 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .rd_data   (code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .overflow  (overflow)
  );

  assign valid         = !fifo_empty;
  assign dbg.state     = state_q;
  assign dbg.fifo_full = fifo_full;

endmodule

// File: tb/tb_key_encoder_buf.sv
module tb_key_encoder_buf;
  import key_enc_pkg::*;

  logic        clk;
  logic        resetn;
  logic        enablen;
  logic [9:0]  key;
  logic        pop;
  logic [3:0]  code;
  logic        valid;
  logic [2:0]  count;
  logic        pressed;
  logic        overflow;
  dbg_t        dbg;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];

  key_encoder_buf #(
    .NUM_KEYS        (10),
    .CODE_W          (4),
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enablen  (enablen),
    .key      (key),
    .pop      (pop),
    .code     (code),
    .valid    (valid),
    .count    (count),
    .pressed  (pressed),
    .overflow (overflow),
    .dbg      (dbg)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after
  // a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full press/release cycle of one key, pushing its code.
  task automatic press(input int idx);
    key = 10'b1 << idx;
    tick(6);
    key = '0;
    tick(8);
  endtask

  // Compare head with the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    logic [3:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
    check_eq(tag, 32'(code), 32'(e));
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    resetn  = 1'b0;
    enablen = 1'b0;
    key     = '0;
    pop     = 1'b0;
    tick(2);
    resetn = 1'b1;

    // Idle after reset
    tick(20);
    check_eq("rst_valid",    32'(valid),    32'd0);
    check_eq("rst_code",     32'(code),     32'd0);
    check_eq("rst_count",    32'(count),    32'd0);
    check_eq("rst_pressed",  32'(pressed),  32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);

    // Single press of key 5: push lands on edge 6
    key = 10'b0000100000;
    tick(5);
    check_eq("k5_valid_e5", 32'(valid), 32'd0);
    tick(1);
    exp_q.push_back(4'd5);
    check_eq("k5_valid_e6", 32'(valid),   32'd1);
    check_eq("k5_code",     32'(code),    32'd5);
    check_eq("k5_count",    32'(count),   32'd1);
    check_eq("k5_pressed",  32'(pressed), 32'd1);
    tick(4);
    key = '0;
    tick(8);
    check_eq("k5_rel_count",   32'(count),   32'd1);
    check_eq("k5_rel_pressed", 32'(pressed), 32'd0);
    pop_check("k5_pop");
    check_eq("k5_empty_valid", 32'(valid), 32'd0);

    // Bouncing key 7 never reaches four stable samples
    for (int i = 0; i < 6; i++) begin
      key = (i % 2 == 0) ? 10'b0010000000 : 10'b0;
      tick(2);
    end
    check_eq("bounce_count", 32'(count), 32'd0);
    key = 10'b0010000000;
    tick(5);
    check_eq("k7_count_e5", 32'(count), 32'd0);
    tick(1);
    exp_q.push_back(4'd7);
    check_eq("k7_count_e6", 32'(count), 32'd1);
    key = '0;
    tick(8);
    pop_check("k7_pop");

    // Two keys: lowest index wins, key change while held gives no push
    key = 10'b1000000100;
    tick(6);
    exp_q.push_back(4'd2);
    check_eq("k2_code",  32'(code),  32'd2);
    check_eq("k2_count", 32'(count), 32'd1);
    key = 10'b1000000000;
    tick(8);
    check_eq("k2_hold_count",   32'(count),   32'd1);
    check_eq("k2_hold_pressed", 32'(pressed), 32'd1);
    key = '0;
    tick(8);
    pop_check("k2_pop");

    // Five presses into a four-entry queue
    for (int i = 1; i <= 4; i++) begin
      press(i);
      exp_q.push_back(4'(i));
    end
    check_eq("fill_count",    32'(count),         32'd4);
    check_eq("fill_overflow", 32'(overflow),      32'd0);
    check_eq("fill_full",     32'(dbg.fifo_full), 32'd1);
    press(5);
    check_eq("drop_count",    32'(count),    32'd4);
    check_eq("drop_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check_eq("drain_count", 32'(count), 32'd0);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    check_eq("pop_empty_count", 32'(count), 32'd0);

    // Refill, then press while full with pop on the push edge
    for (int i = 1; i <= 4; i++) begin
      press(i);
      exp_q.push_back(4'(i));
    end
    key = 10'b0001000000;
    tick(5);
    check_eq("pp_head", 32'(code), 32'(exp_q.pop_front()));
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    exp_q.push_back(4'd6);
    check_eq("pp_count",    32'(count),    32'd4);
    check_eq("pp_overflow", 32'(overflow), 32'd1);
    key = '0;
    tick(8);
    pop_check("pp_pop_a");
    pop_check("pp_pop_b");
    check_eq("pp_left_count", 32'(count), 32'd2);
    check_eq("pp_left_head",  32'(code),  32'(exp_q[0]));

    // Disabled: held key is ignored
    enablen = 1'b1;
    key     = 10'b0000001000;
    tick(10);
    check_eq("dis_count",   32'(count),     32'd2);
    check_eq("dis_pressed", 32'(pressed),   32'd0);
    check_eq("dis_state",   32'(dbg.state), 32'(IDLE));
    key = '0;
    tick(3);
    enablen = 1'b0;
    tick(2);

    // Reset mid-debounce with entries queued
    key = 10'b0000001000;
    tick(4);
    check_eq("mid_state", 32'(dbg.state), 32'(DEBOUNCE));
    resetn = 1'b0;
    tick(1);
    exp_q.delete();
    check_eq("mr_count",    32'(count),     32'd0);
    check_eq("mr_valid",    32'(valid),     32'd0);
    check_eq("mr_overflow", 32'(overflow),  32'd0);
    check_eq("mr_state",    32'(dbg.state), 32'(IDLE));
    resetn = 1'b1;
    key    = '0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_encoder_buf.md
Name: key_encoder_buf

Overview:
Parametrised successor of the microwave keypad encoder. Synchronises and debounces an N-key one-hot-ish keypad and priority-encodes the pressed key to a binary code. Emits exactly one code per press/release cycle and queues codes in a small FIFO for the timer/controller to pop. Sits between the raw keypad inputs and the microwave control FSM.

Parameters:
NUM_KEYS, 10, number of key inputs; key[i] encodes to value i
CODE_W, 4, code width; must satisfy 2**CODE_W >= NUM_KEYS
DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release (>=1)
FIFO_DEPTH, 4, code queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
enablen  in  1  active-low enable; high freezes press detection
key  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
pop  in  1  consume head code this cycle
code  out  CODE_W  FIFO head (show-ahead); 0 when empty
valid  out  1  FIFO non-empty
count  out  $clog2(FIFO_DEPTH)+1  entries held
pressed  out  1  debounced key currently held (state HELD)
overflow  out  1  sticky: a code was dropped on full FIFO

Behaviour:
- Reset (resetn=0 at edge): sync flops, FSM=IDLE, debounce counter, FIFO pointers, count, overflow all 0; code=0, valid=0, pressed=0. Reset mid-debounce or with FIFO full discards everything.
- Input sync: key passes a 2-flop synchroniser; sample s = second stage. Priority: lowest set index of s wins; cand = that index, any = |s.
- FSM states IDLE, DEBOUNCE, HELD, RELEASE; counter cnt.
- IDLE: if enablen=0 and any: latch cand, cnt=1, -> DEBOUNCE.
- DEBOUNCE: if !any or cand != latched: -> IDLE. Else cnt++; when the sample making cnt reach DEBOUNCE_CYCLES is taken: push latched code, -> HELD. DEBOUNCE_CYCLES=1 pushes on the IDLE edge directly and enters HELD.
- HELD: pressed=1; stay while any (changes of key while held are ignored, no second push); on !any: cnt=1, -> RELEASE.
- RELEASE: any -> HELD (bounce); else cnt++; at DEBOUNCE_CYCLES zero samples -> IDLE.
- enablen=1: FSM forced to IDLE next edge from any state, no push; FIFO pop, count, overflow unaffected.
- Latency: key set before edge 1 and held stable -> push on edge DEBOUNCE_CYCLES+2 (2 sync + N samples); valid/code visible after that edge.
- FIFO: push and pop same edge: both occur, count unchanged (also when full: accepted, no overflow). Push when full without pop: dropped, overflow<=1 (cleared only by reset). Pop when empty: ignored. Pointers wrap modulo FIFO_DEPTH.
- Codes are zero-extended index values, CODE_W bits.

Decomposition:
- Package key_enc_pkg: state enum (IDLE, DEBOUNCE, HELD, RELEASE), localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1), priority-encode function.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/overflow) instantiated once; synchroniser, encoder and FSM stay in top.

Test Plan:
- Reset, key=0 for 20 cycles -> valid=0, code=0, count=0, pressed=0, overflow=0.
- key=10'b0000100000 held 10 cycles, enablen=0 -> valid rises after edge 6, code=5, count=1; released 8 cycles -> still one entry, pressed falls; pop -> valid=0.
- key[7] toggles every 2 cycles for 12 cycles (bounce) -> no push, count=0; then stable 6 cycles -> exactly one code 7.
- key=10'b1000000100 held -> code=2 (lowest index wins); hold with key[2] dropped, key[9] still set -> no second push.
- Five separate presses 1,2,3,4,5 with no pop -> count=4, codes pop out 1,2,3,4, overflow=1; press during full with pop asserted on push edge -> accepted, overflow unchanged otherwise.
- enablen=1 while key[3] held 10 cycles -> no push; assert resetn=0 mid-DEBOUNCE with 2 entries queued -> count=0, valid=0, overflow=0 next cycle.
